// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types for the OLED glyph update queue
package oled_pkg;

    localparam int OLED_GLYPH_W = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETUP      = 3'd1,
        S_PULSE      = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_SKIP       = 3'd5
    } oled_q_state_t;

    typedef struct packed {
        logic                    disp;
        logic [OLED_GLYPH_W-1:0] glyph;
    } oled_req_t;

endpackage

// File: rtl/oled_req_fifo.sv
// rtl/oled_req_fifo.sv - synchronous request FIFO with occupancy count
module oled_req_fifo
    import oled_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  oled_req_t                push_data,
    input  logic                     pop,
    output oled_req_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    oled_req_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/oled_update_queue.sv
// rtl/oled_update_queue.sv - request sequencer for the two-display OLED driver; OLED_DEDUP_EN skips repeat glyphs
module oled_update_queue
    import oled_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int GLYPH_W       = OLED_GLYPH_W,
    parameter int PULSE_CYCLES  = 4,
    parameter int START_TIMEOUT = 1024,
    parameter int DONE_TIMEOUT  = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_disp,
    input  logic [GLYPH_W-1:0]       req_glyph,
    output logic [GLYPH_W-1:0]       drv_data,
    output logic                     drv_address_sel,
    output logic                     drv_data_ready,
    input  logic                     drv_busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     timeout_err,
    output logic [GLYPH_W-1:0]       shown_glyph0,
    output logic [GLYPH_W-1:0]       shown_glyph1,
    output logic [1:0]               shown_valid
);

    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] START_LAST = 32'(START_TIMEOUT - 1);
    localparam logic [31:0] DONE_LAST  = 32'(DONE_TIMEOUT - 1);

    oled_q_state_t        state;
    oled_q_state_t        state_next;
    logic [31:0]          cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 load_drv;
    logic                 dup_hit;
    logic                 to_hit;
    logic                 shown_load;
    oled_req_t            push_req;
    oled_req_t            head;
    logic [GLYPH_W-1:0]   shown [2];

    assign req_ready    = !fifo_full;
    assign push         = req_valid && !fifo_full;
    assign push_req     = '{disp: req_disp, glyph: req_glyph};
    assign shown_glyph0 = shown[0];
    assign shown_glyph1 = shown[1];

    oled_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

`ifdef OLED_DEDUP_EN
    assign dup_hit = shown_valid[head.disp] && (shown[head.disp] == head.glyph);
`else
    assign dup_hit = 1'b0;
`endif

    // One counter, cleared on every state change, times PULSE and both waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !drv_busy)
                    state_next = dup_hit ? S_SKIP : S_SETUP;
            end
            S_SETUP:      state_next = S_PULSE;
            S_PULSE: begin
                if (cnt == PULSE_LAST) state_next = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (drv_busy)                state_next = S_WAIT_DONE;
                else if (cnt == START_LAST)  state_next = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!drv_busy)               state_next = S_IDLE;
                else if (cnt == DONE_LAST)   state_next = S_IDLE;
            end
            S_SKIP:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        drv_data_ready = (state == S_PULSE);
        pop            = (state == S_IDLE) && !fifo_empty && !drv_busy;
        load_drv       = pop && !dup_hit;
        to_hit         = ((state == S_WAIT_START) && !drv_busy && (cnt == START_LAST)) ||
                         ((state == S_WAIT_DONE)  &&  drv_busy && (cnt == DONE_LAST));
        shown_load     = (state == S_WAIT_DONE) && !drv_busy;
    end

    // Driver-facing data only changes when a real dispatch leaves IDLE,
    // keeping it quiet around the asynchronous dataReady fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            drv_data        <= '0;
            drv_address_sel <= 1'b0;
            timeout_err     <= 1'b0;
            shown[0]        <= '1;
            shown[1]        <= '1;
            shown_valid     <= 2'b00;
        end else begin
            timeout_err <= to_hit;
            if (load_drv) begin
                drv_data        <= head.glyph;
                drv_address_sel <= head.disp;
            end
            if (shown_load) begin
                shown[drv_address_sel]       <= drv_data;
                shown_valid[drv_address_sel] <= 1'b1;
            end
        end
    end

endmodule
